// File: rtl/sobel_pkg.sv
// Shared constants and window indexing for the Sobel pipeline (line buffers,
// window reader, gradient block).
package sobel_pkg;

  localparam int PIX_W   = 8;
  localparam int COORD_W = 10;
  localparam int WIN_W   = 9 * PIX_W;

  // Byte slot of pixel p[r][c] inside a packed 3x3 window; r=0 top, c=0 left.
  function automatic int idx(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/sobel_window_reader_if.sv
// Pixel-in / window-out bundle between the line-buffer chain, the window reader
// and the gradient datapath.
interface sobel_window_reader_if;
  import sobel_pkg::*;

  logic                 pix_valid_i;
  logic                 frame_start_i;
  logic [PIX_W-1:0]     pix_i;
  logic [PIX_W-1:0]     row1_i;
  logic [PIX_W-1:0]     row2_i;
  logic [WIN_W-1:0]     win_o;
  logic                 win_valid_o;
  logic [COORD_W-1:0]   cx_o;
  logic [COORD_W-1:0]   cy_o;
  logic                 frame_done_o;

  modport master (
    output pix_valid_i, frame_start_i, pix_i, row1_i, row2_i,
    input  win_o, win_valid_o, cx_o, cy_o, frame_done_o
  );

  modport slave (
    input  pix_valid_i, frame_start_i, pix_i, row1_i, row2_i,
    output win_o, win_valid_o, cx_o, cy_o, frame_done_o
  );

endinterface

// File: rtl/raster_counter.sv
// Raster position tracker: col/row hold the position of the pixel being accepted
// this cycle, wrapping at the end of each row and frame.
module raster_counter
  import sobel_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               last_col,
  output logic               last_pix
);

  assign last_col = (col == COORD_W'(WIDTH - 1));
  assign last_pix = last_col && (row == COORD_W'(HEIGHT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      // A clear that coincides with an accept consumes (0,0) in the same cycle.
      col <= en ? COORD_W'(1) : '0;
      row <= '0;
    end else if (en) begin
      if (last_col) begin
        col <= '0;
        row <= last_pix ? '0 : row + COORD_W'(1);
      end else begin
        col <= col + COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/sobel_window_reader.sv
// Reader end of the Sobel line-buffer chain: assembles a registered 3x3 window
// from the live and two delayed rows and tags windows fully inside the frame.
module sobel_window_reader
  import sobel_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  sobel_window_reader_if.slave  bus
);

  logic               accept;
  logic [COORD_W-1:0] col, row;
  logic [COORD_W-1:0] pos_col, pos_row;
  logic               last_col_unused;
  logic               last_pix;
  logic               pos_last;
  logic               win_hit;
  logic [PIX_W-1:0]   col_new [3];

  logic [WIN_W-1:0]   win_p0;
  logic               vld_p0;
  logic               done_p0;
  logic [COORD_W-1:0] cx_p0, cy_p0;

  assign accept = bus.pix_valid_i;

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_raster (
    .clk      (clk),
    .rst      (rst),
    .en       (accept),
    .clr      (bus.frame_start_i),
    .col      (col),
    .row      (row),
    .last_col (last_col_unused),
    .last_pix (last_pix)
  );

  // frame_start_i re-labels the same-cycle pixel as (0,0) before the counter sees it.
  assign pos_col  = bus.frame_start_i ? '0 : col;
  assign pos_row  = bus.frame_start_i ? '0 : row;
  assign pos_last = last_pix && !bus.frame_start_i;
  assign win_hit  = (pos_col >= COORD_W'(2)) && (pos_row >= COORD_W'(2));

  assign col_new[0] = bus.row2_i;
  assign col_new[1] = bus.row1_i;
  assign col_new[2] = bus.pix_i;

  // Stage p0: window shift register and its qualifying control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_p0 <= '0;
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_p0[PIX_W*idx(r, 0) +: PIX_W] <= win_p0[PIX_W*idx(r, 1) +: PIX_W];
        win_p0[PIX_W*idx(r, 1) +: PIX_W] <= win_p0[PIX_W*idx(r, 2) +: PIX_W];
        win_p0[PIX_W*idx(r, 2) +: PIX_W] <= col_new[r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      done_p0 <= 1'b0;
      cx_p0   <= '0;
      cy_p0   <= '0;
    end else begin
      vld_p0  <= accept && win_hit;
      done_p0 <= accept && pos_last;
      if (accept && win_hit) begin
        cx_p0 <= pos_col - COORD_W'(1);
        cy_p0 <= pos_row - COORD_W'(1);
      end
    end
  end

  assign bus.win_o        = win_p0;
  assign bus.win_valid_o  = vld_p0;
  assign bus.cx_o         = cx_p0;
  assign bus.cy_o         = cy_p0;
  assign bus.frame_done_o = done_p0;

endmodule

// File: tb/tb_sobel_window_reader.sv
// Directed bench for sobel_window_reader on a 5x5 frame with an image-based
// scoreboard and modelled line-buffer delays.
module tb_sobel_window_reader;
  import sobel_pkg::*;

  localparam int W = 5;
  localparam int H = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sobel_window_reader_if bus ();

  sobel_window_reader #(
    .WIDTH  (W),
    .HEIGHT (H)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [WIN_W-1:0]   win;
    logic [COORD_W-1:0] cx;
    logic [COORD_W-1:0] cy;
  } exp_t;

  exp_t             sb [$];
  logic [PIX_W-1:0] hist [$];
  logic [PIX_W-1:0] img [H][W];

  int mcol, mrow;
  int n_assert, n_fail;
  int accepts, n_win, n_done;
  int last_done_acc, prev_done_acc, first_win_acc;
  logic [WIN_W-1:0]   first_win, last_win;
  logic [COORD_W-1:0] first_cx, first_cy, last_cx, last_cy;

  task automatic chk(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    mcol = 0;
    mrow = 0;
    hist.delete();
    sb.delete();
  endtask

  task automatic clear_stats();
    n_win = 0;
    n_done = 0;
    first_win_acc = -1;
    last_done_acc = 0;
    prev_done_acc = 0;
  endtask

  // One clock: drive inputs, update the model, then check the registered outputs.
  task automatic step(input logic v, input logic fs, input logic [PIX_W-1:0] p);
    exp_t e;
    logic ev, ed;
    bus.pix_valid_i   = v;
    bus.frame_start_i = fs;
    bus.pix_i         = p;
    bus.row1_i        = (hist.size() >= W)     ? hist[hist.size()-W]     : 8'h00;
    bus.row2_i        = (hist.size() >= 2 * W) ? hist[hist.size()-2*W]   : 8'h00;
    ev = 1'b0;
    ed = 1'b0;
    if (v) begin
      if (fs) begin
        mcol = 0;
        mrow = 0;
      end
      img[mrow][mcol] = p;
      hist.push_back(p);
      if (hist.size() > 2 * W) void'(hist.pop_front());
      accepts++;
      if (mcol >= 2 && mrow >= 2) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.win[8*(3*i+j) +: 8] = img[mrow-2+i][mcol-2+j];
        e.cx = COORD_W'(mcol - 1);
        e.cy = COORD_W'(mrow - 1);
        sb.push_back(e);
        ev = 1'b1;
      end
      ed = (mcol == W - 1) && (mrow == H - 1);
      if (mcol == W - 1) begin
        mcol = 0;
        mrow = (mrow == H - 1) ? 0 : mrow + 1;
      end else begin
        mcol++;
      end
    end else if (fs) begin
      mcol = 0;
      mrow = 0;
    end
    @(posedge clk);
    #1;
    chk("win_valid", bus.win_valid_o, ev);
    chk("frame_done", bus.frame_done_o, ed);
    if (bus.win_valid_o) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", WIN_W'(sb.size()), WIN_W'(1));
      end else begin
        e = sb.pop_front();
        chk("win", bus.win_o, e.win);
        chk("cx", bus.cx_o, e.cx);
        chk("cy", bus.cy_o, e.cy);
      end
      n_win++;
      if (first_win_acc < 0) begin
        first_win_acc = accepts;
        first_win = bus.win_o;
        first_cx  = bus.cx_o;
        first_cy  = bus.cy_o;
      end
      last_win = bus.win_o;
      last_cx  = bus.cx_o;
      last_cy  = bus.cy_o;
    end
    if (bus.frame_done_o) begin
      n_done++;
      prev_done_acc = last_done_acc;
      last_done_acc = accepts;
    end
  endtask

  task automatic run_frame(input int base, input logic fs_first, input logic gaps);
    for (int k = 1; k <= W * H; k++) begin
      if (gaps && $urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, PIX_W'($urandom));
      step(1'b1, fs_first && (k == 1), PIX_W'(base + k));
    end
  endtask

  task automatic check_frame_1x(input string tag);
    chk({tag, "_windows"}, WIN_W'(n_win), WIN_W'(9));
    chk({tag, "_dones"}, WIN_W'(n_done), WIN_W'(1));
    chk({tag, "_first_win"}, first_win, 72'h0d0c0b080706030201);
    chk({tag, "_first_cx"}, first_cx, 1);
    chk({tag, "_first_cy"}, first_cy, 1);
    chk({tag, "_last_win"}, last_win, 72'h1918171413120f0e0d);
    chk({tag, "_last_cx"}, last_cx, 3);
    chk({tag, "_last_cy"}, last_cy, 3);
  endtask

  int fs_acc;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    accepts  = 0;
    rst = 1'b1;
    bus.pix_valid_i   = 1'b0;
    bus.frame_start_i = 1'b0;
    bus.pix_i  = '0;
    bus.row1_i = '0;
    bus.row2_i = '0;
    reset_model();
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_win", bus.win_o, '0);
    chk("rst_valid", bus.win_valid_o, 0);
    chk("rst_cx", bus.cx_o, 0);
    chk("rst_cy", bus.cy_o, 0);
    chk("rst_done", bus.frame_done_o, 0);
    rst = 1'b0;

    // Continuous frame
    run_frame(0, 1'b1, 1'b0);
    check_frame_1x("s1");
    step(1'b0, 1'b0, 8'hff);

    // Same frame with random idle gaps
    clear_stats();
    run_frame(0, 1'b1, 1'b1);
    check_frame_1x("s2");

    // Asynchronous reset mid-frame, then a fresh frame without frame_start
    clear_stats();
    for (int k = 1; k <= 17; k++) step(1'b1, k == 1, PIX_W'(200 + k));
    #3;
    rst = 1'b1;
    #1;
    chk("arst_win", bus.win_o, '0);
    chk("arst_valid", bus.win_valid_o, 0);
    chk("arst_cx", bus.cx_o, 0);
    chk("arst_cy", bus.cy_o, 0);
    chk("arst_done", bus.frame_done_o, 0);
    bus.pix_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    reset_model();
    clear_stats();
    run_frame(0, 1'b0, 1'b0);
    check_frame_1x("s4");

    // frame_start_i on the 8th pixel of a frame restarts the raster there
    for (int k = 1; k <= 7; k++) step(1'b1, k == 1, PIX_W'(100 + k));
    clear_stats();
    fs_acc = accepts + 1;
    run_frame(40, 1'b1, 1'b0);
    chk("s5_windows", WIN_W'(n_win), WIN_W'(9));
    chk("s5_first_lat", WIN_W'(first_win_acc - fs_acc), WIN_W'(12));
    chk("s5_dones", WIN_W'(n_done), WIN_W'(1));

    // frame_start_i alone clears the counters
    for (int k = 1; k <= 3; k++) step(1'b1, 1'b0, PIX_W'(150 + k));
    step(1'b0, 1'b1, 8'h00);
    clear_stats();
    run_frame(0, 1'b0, 1'b0);
    check_frame_1x("fs_idle");

    // Two back-to-back frames
    clear_stats();
    run_frame(0, 1'b1, 1'b0);
    run_frame(120, 1'b0, 1'b0);
    chk("s6_windows", WIN_W'(n_win), WIN_W'(18));
    chk("s6_dones", WIN_W'(n_done), WIN_W'(2));
    chk("s6_done_gap", WIN_W'(last_done_acc - prev_done_acc), WIN_W'(25));
    chk("s6_first_cx", first_cx, 1);
    chk("s6_first_cy", first_cy, 1);
    chk("s6_sb_drained", WIN_W'(sb.size()), WIN_W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_window_reader.md
Name: sobel_window_reader

Overview:
Reader end of the Sobel line-buffer chain. It consumes the live pixel plus the two delayed rows emitted by the two cascaded single-line FIFOs and assembles a registered 3x3 pixel window. It tracks raster position and flags windows whose 3x3 neighbourhood lies fully inside the frame. Its output feeds the Sobel gradient datapath.

Parameters:
WIDTH, 640, pixels per row; sim value 5; must equal the line-buffer DEPTH.
HEIGHT, 480, rows per frame; sim value 5.

Ports:
clk  input  1  system clock; all state on posedge.
rst  input  1  asynchronous active-high reset.
pix_valid_i  input  1  pixel accept strobe; one pixel per cycle when high.
frame_start_i  input  1  synchronous counter clear; qualifies the same-cycle pixel as (0,0).
pix_i  input  8  current-row pixel.
row1_i  input  8  same-column pixel one row earlier (line buffer 1 data_o).
row2_i  input  8  same-column pixel two rows earlier (line buffer 2 data_o).
win_o  output  72  packed window; p[r][c] at bits [8*(3r+c) +: 8]; r=0 top, c=0 left.
win_valid_o  output  1  win_o, cx_o and cy_o are valid this cycle.
cx_o  output  10  window centre column.
cy_o  output  10  window centre row.
frame_done_o  output  1  one-cycle pulse after the last pixel of the frame.

Behaviour:
- Reset (async, rst=1): window regs, counters, cx_o, cy_o, win_valid_o and frame_done_o are all 0 immediately. Mid-frame reset discards the partial frame; the next accepted pixel is (0,0).
- Accept = pix_valid_i. When low, no state changes and win_valid_o/frame_done_o are driven 0. Gaps of any length are legal.
- Window shift on accept:
  - Column 2 (right) <- {row2_i top, row1_i mid, pix_i bottom}.
  - Column 1 <- old column 2.
  - Column 0 <- old column 1.
- Position counters col (0..WIDTH-1) and row (0..HEIGHT-1) hold the position of the pixel being accepted.
  - On accept, col increments. At WIDTH-1, col wraps to 0 and row increments.
  - At (WIDTH-1, HEIGHT-1), both wrap to 0.
- frame_start_i with accept: the pixel is (0,0); counters become col=1, row=0. frame_start_i without accept: counters cleared to 0.
- win_valid_o is registered with 1-cycle latency. It is 1 in the cycle after accepting a pixel at (col>=2, row>=2). In that cycle cx_o=col-1 and cy_o=row-1.
- Windows per frame: (WIDTH-2)*(HEIGHT-2). No border padding. The first two columns of each row produce windows that straddle rows, and these are suppressed.
- Row1/row2 inputs are don't-care during rows 0-1; no window is emitted there.
- frame_done_o is registered: 1 the cycle after accepting (WIDTH-1, HEIGHT-1). It coincides with the final win_valid_o.
- win_o holds its value between accepts. cx_o and cy_o hold their last values when win_valid_o=0.
- Arithmetic: counters are 10-bit unsigned. Comparisons against WIDTH-1 and HEIGHT-1 are exact. No overflow is possible for WIDTH, HEIGHT <= 1024.

Decomposition:
- Package sobel_pkg:
  - PIX_W=8, COORD_W=10, WIN_W=9*PIX_W.
  - Window index function idx(r,c)=3r+c.
  - Shared by the line buffers and the gradient block.
- Sub-module raster_counter:
  - Parameters WIDTH and HEIGHT.
  - Inputs: clk, rst, en, clr.
  - Outputs: col, row, last_col, last_pix.
  - Reused by the future frame writer.

Test Plan:
All scenarios use WIDTH=5, HEIGHT=5.
1. Continuous 25 pixels, pix_i=1..25, row1_i/row2_i modelled as 5- and 10-deep delays -> exactly 9 win_valid_o pulses.
   - First pulse is the cycle after pixel 13: win_o = {1,2,3,6,7,8,11,12,13}, cx_o=1, cy_o=1.
   - Last pulse is the cycle after pixel 25: win_o = {13,14,15,18,19,20,23,24,25}, cx_o=3, cy_o=3.
   - frame_done_o pulses once, coincident with the last window.
2. Same frame with 1-3 idle cycles randomly inserted -> identical window sequence and coordinates. win_valid_o=0 on every idle cycle.
3. Pixels accepted at col 0 and 1 of rows 2-4 -> win_valid_o stays 0. The window emitted at col 2 contains only the current row's columns 0-2.
4. rst asserted asynchronously after pixel 17 (mid-clock) -> all outputs 0 immediately. A fresh 25-pixel frame then reproduces the scenario 1 results exactly.
5. frame_start_i with pix_valid_i on pixel 8 of a frame -> that pixel is treated as (0,0). The first window appears 12 accepts later.
6. Two back-to-back frames with no gap -> 18 windows total and two frame_done_o pulses, 25 accepts apart. Second-frame coordinates restart at cx_o=1, cy_o=1.
